alu_datapath: RTL and testbench
===============================

# alu_datapath

Register-file, bus and ALU datapath that answers the control strobes issued by the ALU control FSM of the microcontroller. Holds general registers G0–G3 and P0–P1, the two ALU operand latches, the ALU result latch and the program counter, and resolves a single shared 16-bit bus driven according to the incoming `*_out` / `ALU_outEN` enables. It implements the arithmetic for opcodes 1001–1111 and exposes flags and debug read ports to the top level.

## Interface
- `DW`, 16, data/bus width
- `PC_W`, 8, program-counter width
- `clk` input 1 — single clock, all state updates on rising edge
- `rst` input 1 — asynchronous, active-low reset
- `instr` input 16 — current instruction word; only `instr[15:12]` (opcode) is used
- `G0_out, G1_out, G2_out, G3_out, P0_out, P1_out` input 1 each — register drives bus
- `G0_in, G1_in, G2_in, G3_in, P0_in, P1_in` input 1 each — register captures bus
- `ALUin1`, `ALUin2` input 1 — capture bus into operand A / operand B
- `ALU_outlach` input 1 — capture ALU result and flags
- `ALU_outEN` input 1 — result latch drives bus
- `PC_inc` input 1 — increment PC
- `ext_we` input 1, `ext_sel` input 3, `ext_wdata` input DW — preload port (sel 0..5 = G0,P0,G1,G2,G3,P1)
- `dbg_sel` input 3 — selects register for `dbg_rdata` (same encoding)
- `bus` output DW — current bus value
- `dbg_rdata` output DW — selected register, 0 for sel 6/7
- `pc` output PC_W — program counter
- `zero`, `carry` output 1 — flags from last latched result
- `bus_conflict` output 1 — more than one bus driver enabled this cycle

## Operation
- Bus (combinational): driver priority `ALU_outEN` > G0 > P0 > G1 > G2 > G3 > P1; no driver → 0. `bus_conflict` = count of enabled drivers ≥ 2.
- Register write: on edge with `Gx_in`/`Px_in` high, register ← `bus`. Several `_in` high → all capture. Bus write beats `ext_we` to the same register; `ext_we` to a different register proceeds in the same cycle.
- `ALUin1` high → A ← `bus`; `ALUin2` high → B ← `bus`; both high → both capture.
- ALU (combinational on A, B, opcode): 1001 ADD A+B, carry = bit DW of sum; 1010 SUB A−B, carry = 1 iff A ≥ B unsigned; 1011 AND; 1100 OR; 1101 XOR; 1110 SHL A by B[3:0]; 1111 SHR logical A by B[3:0]; logic/shift ops carry = 0. All results truncated to DW.
- `ALU_outlach` high with opcode 1001–1111 → R ← result, `zero` ← (result == 0), `carry` ← op carry. Opcode 0000–1000 → R and flags hold.
- `ALU_outlach` and `ALU_outEN` same cycle: bus shows old R; new R visible next cycle.
- `PC_inc` high → pc ← pc+1 per cycle held high, wraps 2^PC_W−1 → 0.
- Reset (`rst` low, any time, including mid-instruction): G0–G3, P0, P1, A, B, R, pc, zero, carry → 0 immediately; `bus` and `bus_conflict` follow strobes (0 when strobes low).

## Timing
- All captures on the same rising edge as the strobe is sampled high; zero-cycle combinational bus.
- Canonical FSM sequence (one strobe set per cycle): c1 src1_out+PC_inc; c2 src1_out+ALUin1 (A valid c3); c4–c5 src2_out, ALUin2 in c5 (B valid c6); c6 ALU_outlach (R valid c7); c7 ALU_outEN; c8 ALU_outEN+dest_in (dest valid c9).
- Source equal to destination is legal: read in c2, overwritten in c8.
- `dbg_rdata`, `pc`, flags change only after the capturing edge.

## Test plan
- Reset: preload G0=0x1234 via ext port, pulse `rst` low mid-cycle → G0, pc, R, flags read 0 asynchronously.
- ADD: G1=0xFFFF, G2=0x0001, drive canonical sequence opcode 1001 src G1 dest G3 → G3=0x0000, zero=1, carry=1, pc=1.
- SUB/shift: P0=0x0005, P1=0x0007, op 1010 dest P0 → P0=0xFFFE, carry=0; then G0=0x8001, G1=0x0004, op 1111 dest G0 → G0=0x0800.
- Bus conflict: G0_out+P1_out with G0=0x00F0, P1=0x0F00 → `bus`=0x00F0, `bus_conflict`=1; ALU_outEN+G2_out → bus = R.
- Illegal opcode: R=0x0042, ALU_outlach with opcode 0011 → R, zero, carry unchanged.
- PC wrap: hold `PC_inc` 256 cycles from 0 → pc=0; concurrent ext_we and G1_in to G1 → bus value wins.

Source files
------------

// File: rtl/alu_datapath.sv
// alu_datapath: the register file, single shared bus, ALU and program
// counter that carry out the control strobes issued by the ALU control FSM.
// Register index encoding, used by the ext and dbg ports and internally:
// 0=G0, 1=P0, 2=G1, 3=G2, 4=G3, 5=P1. Bus priority follows the same order,
// with the result latch (ALU_outEN) ahead of every register.
module alu_datapath #(
    parameter int DW   = 16,
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     instr,
    input  logic            G0_out,
    input  logic            G1_out,
    input  logic            G2_out,
    input  logic            G3_out,
    input  logic            P0_out,
    input  logic            P1_out,
    input  logic            G0_in,
    input  logic            G1_in,
    input  logic            G2_in,
    input  logic            G3_in,
    input  logic            P0_in,
    input  logic            P1_in,
    input  logic            ALUin1,
    input  logic            ALUin2,
    input  logic            ALU_outlach,
    input  logic            ALU_outEN,
    input  logic            PC_inc,
    input  logic            ext_we,
    input  logic [2:0]      ext_sel,
    input  logic [DW-1:0]   ext_wdata,
    input  logic [2:0]      dbg_sel,
    output logic [DW-1:0]   bus,
    output logic [DW-1:0]   dbg_rdata,
    output logic [PC_W-1:0] pc,
    output logic            zero,
    output logic            carry,
    output logic            bus_conflict
);

    localparam int NREG = 6;

    logic [DW-1:0]   regs [NREG];
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [DW-1:0]   res_q;
    logic [DW-1:0]   alu_res;
    logic [DW:0]     sum;
    logic            alu_carry;
    logic            alu_valid;
    logic [3:0]      opcode;
    logic [2:0]      n_drv;
    logic [NREG-1:0] out_en;
    logic [NREG-1:0] in_en;
    logic            unused_instr;

    assign opcode       = instr[15:12];
    assign unused_instr = ^instr[11:0];
    assign out_en = {P1_out, G3_out, G2_out, G1_out, P0_out, G0_out};
    assign in_en  = {P1_in,  G3_in,  G2_in,  G1_in,  P0_in,  G0_in};

    // Bus mux: walk from lowest to highest priority so the last hit wins.
    always_comb begin
        bus = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (out_en[i]) bus = regs[i];
        end
        if (ALU_outEN) bus = res_q;
    end

    // Count enabled drivers; two or more is a conflict.
    always_comb begin
        n_drv = 3'(ALU_outEN);
        for (int i = 0; i < NREG; i++) begin
            n_drv = n_drv + 3'(out_en[i]);
        end
        bus_conflict = (n_drv >= 3'd2);
    end

    // ALU: pure function of the operand latches and the current opcode.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        sum       = {1'b0, op_a} + {1'b0, op_b};
        alu_valid = (opcode >= 4'b1001);
        case (opcode)
            4'b1001: begin
                alu_res   = sum[DW-1:0];
                alu_carry = sum[DW];
            end
            4'b1010: begin
                alu_res   = op_a - op_b;
                alu_carry = (op_a >= op_b);
            end
            4'b1011: alu_res = op_a & op_b;
            4'b1100: alu_res = op_a | op_b;
            4'b1101: alu_res = op_a ^ op_b;
            4'b1110: alu_res = op_a << op_b[3:0];
            4'b1111: alu_res = op_a >> op_b[3:0];
            default: alu_res = '0;
        endcase
    end

    // Register file: a bus capture takes precedence over the ext preload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (in_en[i]) begin
                    regs[i] <= bus;
                end else if (ext_we && (ext_sel == 3'(i))) begin
                    regs[i] <= ext_wdata;
                end
            end
        end
    end

    // Operand latches, result latch with flags, and program counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res_q <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            pc    <= '0;
        end else begin
            if (ALUin1) op_a <= bus;
            if (ALUin2) op_b <= bus;
            if (ALU_outlach && alu_valid) begin
                res_q <= alu_res;
                zero  <= (alu_res == '0);
                carry <= alu_carry;
            end
            if (PC_inc) pc <= pc + 1'b1;
        end
    end

    // Debug read port; unused encodings read as zero.
    always_comb begin
        case (dbg_sel)
            3'd0:    dbg_rdata = regs[0];
            3'd1:    dbg_rdata = regs[1];
            3'd2:    dbg_rdata = regs[2];
            3'd3:    dbg_rdata = regs[3];
            3'd4:    dbg_rdata = regs[4];
            3'd5:    dbg_rdata = regs[5];
            default: dbg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed scenario tasks for alu_datapath, each with
// hand-computed expected values. Register index: 0=G0 1=P0 2=G1 3=G2 4=G3 5=P1.
module tb_alu_datapath;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [5:0]  out_v;
  logic [5:0]  in_v;
  logic        ALUin1, ALUin2, ALU_outlach, ALU_outEN, PC_inc;
  logic        ext_we;
  logic [2:0]  ext_sel;
  logic [15:0] ext_wdata;
  logic [2:0]  dbg_sel;
  logic [15:0] bus;
  logic [15:0] dbg_rdata;
  logic [7:0]  pc;
  logic        zero, carry, bus_conflict;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_pc;

  alu_datapath #(.DW(16), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .G0_out(out_v[0]), .G1_out(out_v[2]), .G2_out(out_v[3]),
    .G3_out(out_v[4]), .P0_out(out_v[1]), .P1_out(out_v[5]),
    .G0_in(in_v[0]), .G1_in(in_v[2]), .G2_in(in_v[3]),
    .G3_in(in_v[4]), .P0_in(in_v[1]), .P1_in(in_v[5]),
    .ALUin1(ALUin1), .ALUin2(ALUin2), .ALU_outlach(ALU_outlach),
    .ALU_outEN(ALU_outEN), .PC_inc(PC_inc),
    .ext_we(ext_we), .ext_sel(ext_sel), .ext_wdata(ext_wdata),
    .dbg_sel(dbg_sel), .bus(bus), .dbg_rdata(dbg_rdata), .pc(pc),
    .zero(zero), .carry(carry), .bus_conflict(bus_conflict)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    out_v = '0; in_v = '0;
    ALUin1 = 0; ALUin2 = 0; ALU_outlach = 0; ALU_outEN = 0; PC_inc = 0;
    ext_we = 0; ext_sel = '0; ext_wdata = '0;
  endtask

  task automatic preload(input int sel, input logic [15:0] d);
    ext_we = 1; ext_sel = 3'(sel); ext_wdata = d;
    cycle();
    ext_we = 0;
  endtask

  task automatic rd(input int sel, output logic [15:0] v);
    dbg_sel = 3'(sel);
    #1;
    v = dbg_rdata;
  endtask

  task automatic pulse_reset();
    rst = 0;
    #2;
    @(negedge clk);
    rst = 1;
    cycle();
    exp_pc = 0;
  endtask

  // Canonical eight-cycle FSM sequence.
  task automatic run_op(input logic [3:0] opc, input int s1, input int s2, input int d);
    instr = {opc, 12'h000};
    out_v = '0; out_v[s1] = 1; PC_inc = 1;   // c1
    cycle();
    PC_inc = 0; ALUin1 = 1;                  // c2
    cycle();
    ALUin1 = 0; out_v = '0;                  // c3
    cycle();
    out_v[s2] = 1;                           // c4
    cycle();
    ALUin2 = 1;                              // c5
    cycle();
    ALUin2 = 0; out_v = '0; ALU_outlach = 1; // c6
    cycle();
    ALU_outlach = 0; ALU_outEN = 1;          // c7
    cycle();
    in_v[d] = 1;                             // c8
    cycle();
    in_v = '0; ALU_outEN = 0;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 0;
    clear_strobes();
    instr = '0; dbg_sel = '0; exp_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (pc !== 8'h00 || zero !== 1'b0 || carry !== 1'b0) $display("FAIL reset_state pc=%h z=%b c=%b exp 00 0 0", pc, zero, carry);
    else pass_cnt++;
    total_cnt++;
    if (bus !== 16'h0000 || bus_conflict !== 1'b0) $display("FAIL reset_bus bus=%h conf=%b exp 0000 0", bus, bus_conflict);
    else pass_cnt++;
    @(negedge clk);
    rst = 1;
    cycle();
    preload(0, 16'h1234);
    rd(0, v);
    total_cnt++;
    if (v !== 16'h1234) $display("FAIL preload_g0 got %h exp 1234", v);
    else pass_cnt++;
  endtask

  task automatic test_add();
    logic [15:0] v;
    preload(2, 16'hFFFF);
    preload(3, 16'h0001);
    preload(4, 16'hAAAA);
    run_op(4'b1001, 2, 3, 4);
    rd(4, v);
    total_cnt++;
    if (v !== 16'h0000) $display("FAIL add_result got %h exp 0000", v);
    else pass_cnt++;
    total_cnt++;
    if (zero !== 1'b1 || carry !== 1'b1) $display("FAIL add_flags z=%b c=%b exp 1 1", zero, carry);
    else pass_cnt++;
    total_cnt++;
    if (pc !== 8'h01) $display("FAIL add_pc got %h exp 01", pc);
    else pass_cnt++;
  endtask

  // Asynchronous reset in the middle of a cycle, with G1, pc and flags nonzero.
  task automatic test_mid_reset();
    dbg_sel = 3'd2;
    #1;
    rst = 0;
    #1;
    total_cnt++;
    if (dbg_rdata !== 16'h0000 || pc !== 8'h00) $display("FAIL midreset_regs g1=%h pc=%h exp 0000 00", dbg_rdata, pc);
    else pass_cnt++;
    total_cnt++;
    if (zero !== 1'b0 || carry !== 1'b0) $display("FAIL midreset_flags z=%b c=%b exp 0 0", zero, carry);
    else pass_cnt++;
    out_v[0] = 1; out_v[1] = 1;
    #1;
    total_cnt++;
    if (bus_conflict !== 1'b1 || bus !== 16'h0000) $display("FAIL midreset_bus bus=%h conf=%b exp 0000 1", bus, bus_conflict);
    else pass_cnt++;
    out_v = '0;
    pulse_reset();
  endtask

  task automatic test_sub();
    logic [15:0] v;
    preload(1, 16'h0005);
    preload(5, 16'h0007);
    run_op(4'b1010, 1, 5, 1);
    rd(1, v);
    total_cnt++;
    if (v !== 16'hFFFE || carry !== 1'b0 || zero !== 1'b0) $display("FAIL sub_borrow p0=%h c=%b z=%b exp fffe 0 0", v, carry, zero);
    else pass_cnt++;
    run_op(4'b1010, 5, 5, 4);
    rd(4, v);
    total_cnt++;
    if (v !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1) $display("FAIL sub_equal g3=%h c=%b z=%b exp 0000 1 1", v, carry, zero);
    else pass_cnt++;
  endtask

  task automatic test_shift();
    logic [15:0] v;
    preload(0, 16'h8001);
    preload(2, 16'h0004);
    run_op(4'b1111, 0, 2, 0);
    rd(0, v);
    total_cnt++;
    if (v !== 16'h0800 || carry !== 1'b0) $display("FAIL shr_result g0=%h c=%b exp 0800 0", v, carry);
    else pass_cnt++;
    run_op(4'b1110, 0, 2, 3);
    rd(3, v);
    total_cnt++;
    if (v !== 16'h8000) $display("FAIL shl_result g2=%h exp 8000", v);
    else pass_cnt++;
    run_op(4'b1101, 3, 0, 4);
    rd(4, v);
    total_cnt++;
    if (v !== 16'h8800 || zero !== 1'b0) $display("FAIL xor_result g3=%h z=%b exp 8800 0", v, zero);
    else pass_cnt++;
    total_cnt++;
    if (pc !== exp_pc) $display("FAIL op_pc got %h exp %h", pc, exp_pc);
    else pass_cnt++;
  endtask

  task automatic test_bus_conflict();
    preload(0, 16'h00F0);
    preload(5, 16'h0F00);
    out_v[0] = 1; out_v[5] = 1;
    #1;
    total_cnt++;
    if (bus !== 16'h00F0 || bus_conflict !== 1'b1) $display("FAIL conflict_g0_p1 bus=%h conf=%b exp 00f0 1", bus, bus_conflict);
    else pass_cnt++;
    out_v[5] = 0;
    #1;
    total_cnt++;
    if (bus !== 16'h00F0 || bus_conflict !== 1'b0) $display("FAIL single_driver bus=%h conf=%b exp 00f0 0", bus, bus_conflict);
    else pass_cnt++;
    out_v = '0; out_v[3] = 1; ALU_outEN = 1;
    #1;
    total_cnt++;
    if (bus !== 16'h8800 || bus_conflict !== 1'b1) $display("FAIL conflict_alu_g2 bus=%h conf=%b exp 8800 1", bus, bus_conflict);
    else pass_cnt++;
    out_v = '0; ALU_outEN = 0;
    cycle();
  endtask

  task automatic test_illegal_opcode();
    logic [15:0] v;
    preload(0, 16'h0040);
    preload(2, 16'h0002);
    run_op(4'b1001, 0, 2, 3);
    rd(3, v);
    total_cnt++;
    if (v !== 16'h0042) $display("FAIL r_setup g2=%h exp 0042", v);
    else pass_cnt++;
    instr = 16'h3000; ALU_outlach = 1;
    cycle();
    instr = 16'h8000;
    cycle();
    ALU_outlach = 0; ALU_outEN = 1;
    #1;
    total_cnt++;
    if (bus !== 16'h0042 || zero !== 1'b0 || carry !== 1'b0) $display("FAIL illegal_hold r=%h z=%b c=%b exp 0042 0 0", bus, zero, carry);
    else pass_cnt++;
    // latch and drive together: bus shows old R this cycle
    instr = 16'hB000; ALU_outlach = 1;
    #1;
    total_cnt++;
    if (bus !== 16'h0042) $display("FAIL latch_en_old bus=%h exp 0042", bus);
    else pass_cnt++;
    cycle();
    ALU_outlach = 0;
    total_cnt++;
    if (bus !== 16'h0000 || zero !== 1'b1) $display("FAIL latch_en_new bus=%h z=%b exp 0000 1", bus, zero);
    else pass_cnt++;
    instr = 16'hA000; ALU_outlach = 1;
    cycle();
    instr = 16'h0000;
    cycle();
    ALU_outlach = 0;
    total_cnt++;
    if (bus !== 16'h003E || carry !== 1'b1 || zero !== 1'b0) $display("FAIL sub_then_illegal r=%h c=%b z=%b exp 003e 1 0", bus, carry, zero);
    else pass_cnt++;
    ALU_outEN = 0;
  endtask

  task automatic test_pc_wrap();
    pulse_reset();
    PC_inc = 1;
    repeat (255) cycle();
    total_cnt++;
    if (pc !== 8'hFF) $display("FAIL pc_max got %h exp ff", pc);
    else pass_cnt++;
    cycle();
    PC_inc = 0;
    total_cnt++;
    if (pc !== 8'h00) $display("FAIL pc_wrap got %h exp 00", pc);
    else pass_cnt++;
  endtask

  task automatic test_ext_vs_bus();
    logic [15:0] v;
    preload(0, 16'h1111);
    out_v[0] = 1; in_v[2] = 1;
    ext_we = 1; ext_sel = 3'd2; ext_wdata = 16'h2222;
    cycle();
    out_v = '0; in_v = '0; ext_we = 0;
    rd(2, v);
    total_cnt++;
    if (v !== 16'h1111) $display("FAIL bus_beats_ext g1=%h exp 1111", v);
    else pass_cnt++;
    preload(0, 16'h4444);
    out_v[0] = 1; in_v[2] = 1;
    ext_we = 1; ext_sel = 3'd3; ext_wdata = 16'h3333;
    cycle();
    out_v = '0; in_v = '0; ext_we = 0;
    rd(2, v);
    total_cnt++;
    if (v !== 16'h4444) $display("FAIL parallel_bus g1=%h exp 4444", v);
    else pass_cnt++;
    rd(3, v);
    total_cnt++;
    if (v !== 16'h3333) $display("FAIL parallel_ext g2=%h exp 3333", v);
    else pass_cnt++;
    rd(6, v);
    total_cnt++;
    if (v !== 16'h0000) $display("FAIL dbg_sel6 got %h exp 0000", v);
    else pass_cnt++;
  endtask

  // test sequence and final report
  initial begin
    test_reset();
    test_add();
    test_mid_reset();
    test_sub();
    test_shift();
    test_bus_conflict();
    test_illegal_opcode();
    test_pc_wrap();
    test_ext_vs_bus();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
